// File: rtl/alu_pkg.sv
// Shared constants for the 32-bit ALU and its issue-stage sequencer.
package alu_pkg;

    localparam int WIDTH = 32;

    localparam logic [2:0] F_AND = 3'b000;
    localparam logic [2:0] F_OR  = 3'b001;
    localparam logic [2:0] F_ADD = 3'b010;
    localparam logic [2:0] F_SUB = 3'b110;
    localparam logic [2:0] F_SLT = 3'b111;

endpackage

// File: rtl/alu_regfile.sv
// NREG x WIDTH register file: two combinational read ports, r0 hardwired to zero,
// EX writeback takes priority over a host load to the same register.
module alu_regfile #(
    parameter int WIDTH = 32,
    parameter int AW    = 3,
    parameter int NREG  = 2 ** AW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [AW-1:0]    ra1,
    output logic [WIDTH-1:0] rd1,
    input  logic [AW-1:0]    ra2,
    output logic [WIDTH-1:0] rd2,
    input  logic             ex_we,
    input  logic [AW-1:0]    ex_addr,
    input  logic [WIDTH-1:0] ex_data,
    input  logic             host_we,
    input  logic [AW-1:0]    host_addr,
    input  logic [WIDTH-1:0] host_data
);

    logic [WIDTH-1:0] regs [NREG];

    // NOTE: the array is reset because the design guarantees all registers read 0
    // after reset; a memory that may come up random would drop this branch.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else begin
            // Per-entry priority lets a host load and an unrelated writeback land together.
            for (int i = 1; i < NREG; i++) begin
                if (ex_we && ex_addr == AW'(i))
                    regs[i] <= ex_data;
                else if (host_we && host_addr == AW'(i))
                    regs[i] <= host_data;
            end
        end
    end

    assign rd1 = (ra1 == '0) ? '0 : regs[ra1];
    assign rd2 = (ra2 == '0) ? '0 : regs[ra2];

endmodule

// File: rtl/alu_op_sequencer.sv
// Issue stage for the external combinational ALU: operand fetch with forwarding,
// a registered execute stage driving the ALU, writeback and a result strobe.
module alu_op_sequencer #(
    parameter int WIDTH = alu_pkg::WIDTH,
    parameter int AW    = 3,
    parameter int NREG  = 2 ** AW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_f,
    input  logic [AW-1:0]    cmd_rd,
    input  logic [AW-1:0]    cmd_rs1,
    input  logic [AW-1:0]    cmd_rs2,
    input  logic             cmd_imm_sel,
    input  logic [WIDTH-1:0] cmd_imm,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_f,
    input  logic [WIDTH-1:0] alu_y,
    input  logic             alu_zero,
    output logic             res_valid,
    output logic [AW-1:0]    res_rd,
    output logic [WIDTH-1:0] res_y,
    output logic             res_zero,
    output logic [15:0]      op_count
);

    logic             accept;
    logic             ex_valid;
    logic [AW-1:0]    ex_rd;
    logic [WIDTH-1:0] rf_a;
    logic [WIDTH-1:0] rf_b;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;

    assign cmd_ready = ~wr_en & ~rst;
    assign accept    = cmd_valid & cmd_ready;

    alu_regfile #(
        .WIDTH (WIDTH),
        .AW    (AW),
        .NREG  (NREG)
    ) u_regfile (
        .clk       (clk),
        .rst       (rst),
        .ra1       (cmd_rs1),
        .rd1       (rf_a),
        .ra2       (cmd_rs2),
        .rd2       (rf_b),
        .ex_we     (ex_valid),
        .ex_addr   (ex_rd),
        .ex_data   (alu_y),
        .host_we   (wr_en),
        .host_addr (wr_addr),
        .host_data (wr_data)
    );

    // Forward the in-flight ALU result; rsX != 0 already excludes an r0 destination.
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        op_a = rf_a;
        op_b = rf_b;
        if (cmd_rs1 == '0)
            op_a = '0;
        else if (ex_valid && ex_rd == cmd_rs1)
            op_a = alu_y;
        if (cmd_imm_sel)
            op_b = cmd_imm;
        else if (cmd_rs2 == '0)
            op_b = '0;
        else if (ex_valid && ex_rd == cmd_rs2)
            op_b = alu_y;
    end

    // The EX registers are the ALU operand ports; they hold when no command is accepted.
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid  <= 1'b0;
            ex_rd     <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_f     <= '0;
            res_valid <= 1'b0;
            res_rd    <= '0;
            res_y     <= '0;
            res_zero  <= 1'b0;
            op_count  <= '0;
        end else begin
            ex_valid  <= accept;
            res_valid <= ex_valid;
            if (accept) begin
                alu_a <= op_a;
                alu_b <= op_b;
                alu_f <= cmd_f;
                ex_rd <= cmd_rd;
            end
            if (ex_valid) begin
                res_rd   <= ex_rd;
                res_y    <= alu_y;
                res_zero <= alu_zero;
                if (op_count != 16'hFFFF)
                    op_count <= op_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural ALU beside it.
module tb_alu_op_sequencer;
    import alu_pkg::*;

    localparam int W = 32;
    localparam int A = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    cmd_f;
    logic [A-1:0]  cmd_rd;
    logic [A-1:0]  cmd_rs1;
    logic [A-1:0]  cmd_rs2;
    logic          cmd_imm_sel;
    logic [W-1:0]  cmd_imm;
    logic          wr_en;
    logic [A-1:0]  wr_addr;
    logic [W-1:0]  wr_data;
    logic [W-1:0]  alu_a;
    logic [W-1:0]  alu_b;
    logic [2:0]    alu_f;
    logic [W-1:0]  alu_y;
    logic          alu_zero;
    logic          res_valid;
    logic [A-1:0]  res_rd;
    logic [W-1:0]  res_y;
    logic          res_zero;
    logic [15:0]   op_count;

    int errors = 0;
    int checks = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    alu_op_sequencer #(.WIDTH(W), .AW(A), .NREG(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_f       (cmd_f),
        .cmd_rd      (cmd_rd),
        .cmd_rs1     (cmd_rs1),
        .cmd_rs2     (cmd_rs2),
        .cmd_imm_sel (cmd_imm_sel),
        .cmd_imm     (cmd_imm),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_f       (alu_f),
        .alu_y       (alu_y),
        .alu_zero    (alu_zero),
        .res_valid   (res_valid),
        .res_rd      (res_rd),
        .res_y       (res_y),
        .res_zero    (res_zero),
        .op_count    (op_count)
    );

    // Behavioural stand-in for the external ALU.
    always_comb begin
        case (alu_f)
            F_AND:   alu_y = alu_a & alu_b;
            F_OR:    alu_y = alu_a | alu_b;
            F_ADD:   alu_y = alu_a + alu_b;
            F_SUB:   alu_y = alu_a - alu_b;
            F_SLT:   alu_y = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
            default: alu_y = '0;
        endcase
        alu_zero = (alu_y == '0);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input logic [2:0] f, input logic [A-1:0] rd, input logic [A-1:0] rs1,
                           input logic [A-1:0] rs2, input logic isel, input logic [W-1:0] imm);
        cmd_valid   = 1'b1;
        cmd_f       = f;
        cmd_rd      = rd;
        cmd_rs1     = rs1;
        cmd_rs2     = rs2;
        cmd_imm_sel = isel;
        cmd_imm     = imm;
    endtask

    task automatic host_wr(input logic [A-1:0] addr, input logic [W-1:0] data);
        wr_en   = 1'b1;
        wr_addr = addr;
        wr_data = data;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic check_res(input string tag, input logic [A-1:0] rd, input logic [W-1:0] y,
                             input logic zero);
        exp_cnt++;
        check({tag, "_valid"}, 32'(res_valid), 32'd1);
        check({tag, "_rd"},    32'(res_rd),    32'(rd));
        check({tag, "_y"},     res_y,          y);
        check({tag, "_zero"},  32'(res_zero),  32'(zero));
        check({tag, "_cnt"},   32'(op_count),  32'(exp_cnt));
    endtask

    // Single isolated op: accept edge, then the result edge.
    task automatic do_op(input string tag, input logic [2:0] f, input logic [A-1:0] rd,
                         input logic [A-1:0] rs1, input logic [A-1:0] rs2, input logic isel,
                         input logic [W-1:0] imm, input logic [W-1:0] y, input logic zero);
        set_cmd(f, rd, rs1, rs2, isel, imm);
        tick();
        cmd_valid = 1'b0;
        tick();
        check_res(tag, rd, y, zero);
    endtask

    initial begin
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_f = '0; cmd_rd = '0; cmd_rs1 = '0; cmd_rs2 = '0;
        cmd_imm_sel = 1'b0; cmd_imm = '0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        tick();
        tick();
        check("rst_ready", 32'(cmd_ready), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_alu_a", alu_a, 32'd0);
        check("rst_count", 32'(op_count), 32'd0);
        rst = 1'b0;
        #1;
        check("ready_idle", 32'(cmd_ready), 32'd1);

        // Host loads, then ADD r3 = r1 + r2 with cycle-accurate result timing.
        host_wr(3'd1, 32'h5);
        host_wr(3'd2, 32'h3);
        set_cmd(F_ADD, 3'd3, 3'd1, 3'd2, 1'b0, '0);
        tick();
        cmd_valid = 1'b0;
        check("add_early_valid", 32'(res_valid), 32'd0);
        check("add_alu_a", alu_a, 32'h5);
        check("add_alu_b", alu_b, 32'h3);
        check("add_alu_f", 32'(alu_f), 32'(F_ADD));
        tick();
        check_res("add", 3'd3, 32'h8, 1'b0);
        tick();
        check("add_strobe_once", 32'(res_valid), 32'd0);
        check("alu_a_holds", alu_a, 32'h5);

        // Back-to-back dependent ops: SUB r4 = r1 - r1, OR r5 = r4 | 0xF0 (forwarded).
        set_cmd(F_SUB, 3'd4, 3'd1, 3'd1, 1'b0, '0);
        tick();
        set_cmd(F_OR, 3'd5, 3'd4, 3'd7, 1'b1, 32'hF0);
        tick();
        cmd_valid = 1'b0;
        check_res("sub", 3'd4, 32'h0, 1'b1);
        tick();
        check_res("or_fwd", 3'd5, 32'hF0, 1'b0);

        // SLT pair into r6, then read r6 back from the register file.
        set_cmd(F_SLT, 3'd6, 3'd2, 3'd1, 1'b0, '0);
        tick();
        set_cmd(F_SLT, 3'd6, 3'd1, 3'd2, 1'b0, '0);
        tick();
        cmd_valid = 1'b0;
        check_res("slt_lt", 3'd6, 32'h1, 1'b0);
        tick();
        check_res("slt_ge", 3'd6, 32'h0, 1'b1);
        do_op("r6_read", F_ADD, 3'd7, 3'd6, 3'd0, 1'b0, '0, 32'h0, 1'b1);

        // rd = r0 reports its result, but neither forwards nor sticks.
        set_cmd(F_ADD, 3'd0, 3'd1, 3'd2, 1'b0, '0);
        tick();
        set_cmd(F_ADD, 3'd7, 3'd0, 3'd1, 1'b0, '0);
        tick();
        cmd_valid = 1'b0;
        check_res("r0_wr", 3'd0, 32'h8, 1'b0);
        tick();
        check_res("r0_nofwd", 3'd7, 32'h5, 1'b0);
        do_op("r0_read", F_OR, 3'd7, 3'd0, 3'd0, 1'b0, '0, 32'h0, 1'b1);

        // Host write blocks acceptance.
        set_cmd(F_ADD, 3'd7, 3'd1, 3'd1, 1'b0, '0);
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 32'h3;
        #1;
        check("wr_blocks_ready", 32'(cmd_ready), 32'd0);
        tick();
        wr_en = 1'b0;
        cmd_valid = 1'b0;
        tick();
        check("blocked_no_res", 32'(res_valid), 32'd0);
        check("blocked_count", 32'(op_count), 32'(exp_cnt));

        // EX writeback beats a same-cycle host write to r3.
        set_cmd(F_ADD, 3'd3, 3'd1, 3'd1, 1'b0, '0);
        tick();
        cmd_valid = 1'b0;
        wr_en = 1'b1; wr_addr = 3'd3; wr_data = 32'hDEAD;
        tick();
        wr_en = 1'b0;
        check_res("wb_vs_host", 3'd3, 32'hA, 1'b0);
        do_op("r3_read", F_ADD, 3'd7, 3'd3, 3'd0, 1'b0, '0, 32'hA, 1'b0);

        // Reset the cycle after an accept: op discarded, registers cleared.
        set_cmd(F_ADD, 3'd4, 3'd1, 3'd2, 1'b0, '0);
        tick();
        cmd_valid = 1'b0;
        rst = 1'b1;
        tick();
        check("mid_rst_valid", 32'(res_valid), 32'd0);
        check("mid_rst_count", 32'(op_count), 32'd0);
        check("mid_rst_alu_b", alu_b, 32'd0);
        rst = 1'b0;
        tick();
        check("post_rst_valid", 32'(res_valid), 32'd0);
        exp_cnt = 0;
        do_op("clr_r1r2", F_ADD, 3'd7, 3'd1, 3'd2, 1'b0, '0, 32'h0, 1'b1);
        do_op("clr_r3r5", F_OR, 3'd7, 3'd3, 3'd5, 1'b0, '0, 32'h0, 1'b1);

        // Saturation: stream 65540 ops at one per cycle.
        host_wr(3'd1, 32'h1);
        set_cmd(F_ADD, 3'd2, 3'd1, 3'd0, 1'b0, '0);
        for (int i = 1; i <= 65540; i++) begin
            tick();
            if (i == 100) begin
                check("stream_valid", 32'(res_valid), 32'd1);
                check("stream_count", 32'(op_count), 32'(exp_cnt + 99));
            end
        end
        cmd_valid = 1'b0;
        tick();
        tick();
        check("sat_count", 32'(op_count), 32'hFFFF);
        check("sat_res_y", res_y, 32'h1);
        check("sat_idle", 32'(res_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
